pipe_rx_deframer: RTL and testbench

Sits directly downstream of the host pipe-in FIFO on the sys_clk side. Pops 16-bit words from the host stream and parses them into packets: header, payload, and an optional checksum trailer. Presents the payload as a ready/valid stream with start-of-packet and end-of-packet markers and a latched opcode. Absorbs the one-cycle pop-to-data latency of the upstream FIFO with a small internal buffer.

---
 rtl/pipe_rx_deframer_pkg.sv | 18 +
 rtl/pipe_skid_fifo.sv | 60 ++++++
 rtl/pipe_rx_deframer.sv | 177 +++++++++++++++++
 tb/tb_pipe_rx_deframer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_rx_deframer_pkg.sv
// Shared definitions for the host-stream deframer: FSM encodings, buffer sizing
// and the 16-bit checksum helper.
package pipe_rx_deframer_pkg;

  localparam logic [1:0] ST_HDR = 2'd0;
  localparam logic [1:0] ST_PAY = 2'd1;
  localparam logic [1:0] ST_TRL = 2'd2;

  localparam int unsigned BUF_DEPTH       = 4;
  localparam int unsigned RX_READY_THRESH = 3;
  localparam int unsigned PTR_W           = $clog2(BUF_DEPTH);
  localparam int unsigned OCC_W           = $clog2(BUF_DEPTH + 1);

  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/pipe_skid_fifo.sv
// Small synchronous FIFO absorbing the pop-to-data latency of the upstream FIFO.
module pipe_skid_fifo
  import pipe_rx_deframer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [15:0]      din,
  input  logic             pop,
  output logic [15:0]      head,
  output logic             empty,
  output logic [OCC_W-1:0] occ
);

  logic [15:0]      mem_q [BUF_DEPTH];
  logic [15:0]      mem_d [BUF_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_pop;

  assign do_pop = pop & (occ_q != '0);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push, do_pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign empty = (occ_q == '0);
  assign occ   = occ_q;

endmodule

// File: rtl/pipe_rx_deframer.sv
// Parses the host 16-bit word stream into header/payload/trailer packets.
// Optional checksum trailer: define PIPE_DEFRAMER_CHECKSUM_EN.
module pipe_rx_deframer
  import pipe_rx_deframer_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned LEN_W    = 12,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  output logic                sys_rx_ready,
  input  logic                sys_rx_valid,
  input  logic [15:0]         sys_rx,
  output logic                pkt_valid,
  input  logic                pkt_ready,
  output logic [15:0]         pkt_data,
  output logic                pkt_sop,
  output logic                pkt_eop,
  output logic [OPCODE_W-1:0] pkt_opcode,
  output logic                hdr_err,
  output logic                chk_ok,
  output logic                chk_err,
  output logic [CNT_W-1:0]    pkt_count
);

  localparam int unsigned OPC_LSB = 16 - OPCODE_W;

  logic [15:0]         head;
  logic                empty;
  logic [OCC_W-1:0]    occ;
  logic                push, pop;
  logic                rx_ready, pay_valid, xfer, last;

  logic                in_flight_q, in_flight_d;
  logic [1:0]          state_q, state_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic                first_q, first_d;
  logic [CNT_W-1:0]    pkt_count_q, pkt_count_d;
  logic                hdr_err_q, hdr_err_d;
`ifdef PIPE_DEFRAMER_CHECKSUM_EN
  logic [15:0]         sum_q, sum_d;
  logic                chk_ok_q, chk_ok_d;
  logic                chk_err_q, chk_err_d;
`endif

  // Counting the in-flight word keeps the buffer from ever being over-requested.
  assign rx_ready = ~sys_rst &
                    (({1'b0, occ} + (OCC_W + 1)'(in_flight_q)) < (OCC_W + 1)'(RX_READY_THRESH));
  assign push     = sys_rx_valid & ~sys_rst;

  pipe_skid_fifo u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (push),
    .din   (sys_rx),
    .pop   (pop),
    .head  (head),
    .empty (empty),
    .occ   (occ)
  );

  assign pay_valid = ~sys_rst & (state_q == ST_PAY) & ~empty;
  assign xfer      = pay_valid & pkt_ready;
  assign last      = (remaining_q == LEN_W'(1));

  always_comb begin
    in_flight_d = rx_ready;
    state_d     = state_q;
    remaining_d = remaining_q;
    opcode_d    = opcode_q;
    first_d     = first_q;
    pkt_count_d = pkt_count_q;
    hdr_err_d   = 1'b0;
    pop         = 1'b0;
`ifdef PIPE_DEFRAMER_CHECKSUM_EN
    sum_d       = sum_q;
    chk_ok_d    = 1'b0;
    chk_err_d   = 1'b0;
`endif
    case (state_q)
      ST_HDR: begin
        if (!empty) begin
          pop         = 1'b1;
          opcode_d    = head[15:OPC_LSB];
          remaining_d = head[LEN_W-1:0];
          first_d     = 1'b1;
`ifdef PIPE_DEFRAMER_CHECKSUM_EN
          sum_d       = head;
`endif
          if (head[LEN_W-1:0] == '0) hdr_err_d = 1'b1;
          else                       state_d   = ST_PAY;
        end
      end
      ST_PAY: begin
        if (xfer) begin
          pop         = 1'b1;
          remaining_d = remaining_q - 1'b1;
          first_d     = 1'b0;
`ifdef PIPE_DEFRAMER_CHECKSUM_EN
          sum_d       = csum_add(sum_q, head);
`endif
          if (last) begin
            pkt_count_d = pkt_count_q + 1'b1;
`ifdef PIPE_DEFRAMER_CHECKSUM_EN
            state_d     = ST_TRL;
`else
            state_d     = ST_HDR;
`endif
          end
        end
      end
      ST_TRL: begin
`ifdef PIPE_DEFRAMER_CHECKSUM_EN
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_HDR;
          if (csum_add(sum_q, head) == '0) chk_ok_d  = 1'b1;
          else                             chk_err_d = 1'b1;
        end
`else
        state_d = ST_HDR;
`endif
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      in_flight_q <= 1'b0;
      state_q     <= ST_HDR;
      remaining_q <= '0;
      opcode_q    <= '0;
      first_q     <= 1'b0;
      pkt_count_q <= '0;
      hdr_err_q   <= 1'b0;
`ifdef PIPE_DEFRAMER_CHECKSUM_EN
      sum_q       <= '0;
      chk_ok_q    <= 1'b0;
      chk_err_q   <= 1'b0;
`endif
    end else begin
      in_flight_q <= in_flight_d;
      state_q     <= state_d;
      remaining_q <= remaining_d;
      opcode_q    <= opcode_d;
      first_q     <= first_d;
      pkt_count_q <= pkt_count_d;
      hdr_err_q   <= hdr_err_d;
`ifdef PIPE_DEFRAMER_CHECKSUM_EN
      sum_q       <= sum_d;
      chk_ok_q    <= chk_ok_d;
      chk_err_q   <= chk_err_d;
`endif
    end
  end

  // Registered outputs are masked so every output reads 0 throughout reset.
  assign sys_rx_ready = rx_ready;
  assign pkt_valid    = pay_valid;
  assign pkt_data     = sys_rst ? '0 : head;
  assign pkt_sop      = pay_valid & first_q;
  assign pkt_eop      = pay_valid & last;
  assign pkt_opcode   = sys_rst ? '0 : opcode_q;
  assign pkt_count    = sys_rst ? '0 : pkt_count_q;
  assign hdr_err      = hdr_err_q & ~sys_rst;
`ifdef PIPE_DEFRAMER_CHECKSUM_EN
  assign chk_ok       = chk_ok_q & ~sys_rst;
  assign chk_err      = chk_err_q & ~sys_rst;
`else
  assign chk_ok       = 1'b0;
  assign chk_err      = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_rx_deframer.sv
// Directed bench for pipe_rx_deframer; trailer words and checksum pulses follow
// PIPE_DEFRAMER_CHECKSUM_EN.
module tb_pipe_rx_deframer;

`ifdef PIPE_DEFRAMER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        sys_rx_ready;
  logic        sys_rx_valid = 1'b0;
  logic [15:0] sys_rx = '0;
  logic        pkt_valid;
  logic        pkt_ready = 1'b1;
  logic [15:0] pkt_data;
  logic        pkt_sop, pkt_eop;
  logic [3:0]  pkt_opcode;
  logic        hdr_err, chk_ok, chk_err;
  logic [15:0] pkt_count;

  pipe_rx_deframer #(.OPCODE_W(4), .LEN_W(12), .CNT_W(16)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .sys_rx_ready (sys_rx_ready),
    .sys_rx_valid (sys_rx_valid),
    .sys_rx       (sys_rx),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .pkt_data     (pkt_data),
    .pkt_sop      (pkt_sop),
    .pkt_eop      (pkt_eop),
    .pkt_opcode   (pkt_opcode),
    .hdr_err      (hdr_err),
    .chk_ok       (chk_ok),
    .chk_err      (chk_err),
    .pkt_count    (pkt_count)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] up_q [$];
  logic [15:0] cap_data [$];
  logic [5:0]  cap_info [$];
  int hdr_err_n, chk_ok_n, chk_err_n, rdy_low_n;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Upstream FIFO model: a pop accepted at an edge returns its word one cycle later.
  initial begin
    logic up_pop;
    forever begin
      @(negedge sys_clk);
      up_pop = sys_rx_ready;
      @(posedge sys_clk);
      #1;
      if (up_pop && up_q.size() > 0) begin
        sys_rx_valid = 1'b1;
        sys_rx       = up_q.pop_front();
      end else begin
        sys_rx_valid = 1'b0;
        sys_rx       = '0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      if (!sys_rst) begin
        if (pkt_valid && pkt_ready) begin
          cap_data.push_back(pkt_data);
          cap_info.push_back({pkt_sop, pkt_eop, pkt_opcode});
        end
        if (hdr_err)       hdr_err_n++;
        if (chk_ok)        chk_ok_n++;
        if (chk_err)       chk_err_n++;
        if (!sys_rx_ready) rdy_low_n++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    cap_data.delete();
    cap_info.delete();
    hdr_err_n = 0;
    chk_ok_n  = 0;
    chk_err_n = 0;
    rdy_low_n = 0;
  endtask

  task automatic do_reset(input int n);
    sys_rst = 1'b1;
    up_q.delete();
    repeat (n) begin
      @(negedge sys_clk);
      check("rst_outputs",
            {sys_rx_ready, pkt_valid, pkt_data, pkt_sop, pkt_eop, pkt_opcode,
             hdr_err, chk_ok, chk_err, pkt_count}, 64'h0);
      tick();
    end
    sys_rst   = 1'b0;
    pkt_ready = 1'b1;
    clear_obs();
  endtask

  task automatic push_w(input logic [15:0] w);
    up_q.push_back(w);
  endtask

  task automatic wait_words(input int n);
    int t;
    t = 0;
    while (cap_data.size() < n && t < 300) begin
      tick();
      t++;
    end
    check("words_received", cap_data.size(), n);
    repeat (6) tick();
  endtask

  task automatic check_word(input int i, input logic [15:0] d, input logic sop,
                            input logic eop, input logic [3:0] opc);
    if (i < cap_data.size()) begin
      check($sformatf("w%0d_data", i), cap_data[i], d);
      check($sformatf("w%0d_sop_eop_opc", i), cap_info[i], {sop, eop, opc});
    end else begin
      check($sformatf("w%0d_missing", i), cap_data.size(), i + 1);
    end
  endtask

  task automatic send_first_pkt();
    push_w(16'h3002);
    push_w(16'h1111);
    push_w(16'h2222);
`ifdef PIPE_DEFRAMER_CHECKSUM_EN
    push_w(16'h9CCB);
`endif
  endtask

  task automatic check_first_pkt(input string tag);
    wait_words(2);
    check_word(0, 16'h1111, 1'b1, 1'b0, 4'h3);
    check_word(1, 16'h2222, 1'b0, 1'b1, 4'h3);
    check({tag, "_opcode_held"}, pkt_opcode, 4'h3);
    check({tag, "_chk_ok"}, chk_ok_n, CK);
    check({tag, "_chk_err"}, chk_err_n, 0);
    check({tag, "_count"}, pkt_count, 1);
  endtask

  initial begin
    int t;
    tick();
    do_reset(3);

    // Good packet
    send_first_pkt();
    check_first_pkt("s1");

    // Bad trailer
    do_reset(2);
    push_w(16'h3002);
    push_w(16'h1111);
    push_w(16'h2222);
`ifdef PIPE_DEFRAMER_CHECKSUM_EN
    push_w(16'h0000);
`endif
    wait_words(2);
    check_word(1, 16'h2222, 1'b0, 1'b1, 4'h3);
    check("s2_chk_err", chk_err_n, CK);
    check("s2_chk_ok", chk_ok_n, 0);
    check("s2_count", pkt_count, 1);

    // Zero-length header discarded, following packet intact
    do_reset(2);
    push_w(16'h5000);
    send_first_pkt();
    wait_words(2);
    check("s3_hdr_err", hdr_err_n, 1);
    check_word(0, 16'h1111, 1'b1, 1'b0, 4'h3);
    check_word(1, 16'h2222, 1'b0, 1'b1, 4'h3);
    check("s3_chk_ok", chk_ok_n, CK);
    check("s3_count", pkt_count, 1);

    // Downstream stall mid-packet
    do_reset(2);
    push_w(16'h1008);
    for (int i = 0; i < 8; i++) push_w(16'hA000 + 16'(i));
`ifdef PIPE_DEFRAMER_CHECKSUM_EN
    push_w(16'hEFDC);
`endif
    t = 0;
    while (cap_data.size() < 3 && t < 100) begin
      tick();
      t++;
    end
    pkt_ready = 1'b0;
    rdy_low_n = 0;
    repeat (10) tick();
    check("s4_stall_hold", cap_data.size(), 3);
    check("s4_stall_rdy_low", rdy_low_n != 0, 1);
    pkt_ready = 1'b1;
    wait_words(8);
    for (int i = 0; i < 8; i++)
      check_word(i, 16'hA000 + 16'(i), i == 0, i == 7, 4'h1);
    check("s4_chk_ok", chk_ok_n, CK);
    check("s4_count", pkt_count, 1);

    // Single-word packet
    do_reset(2);
    push_w(16'h7001);
    push_w(16'hBEEF);
`ifdef PIPE_DEFRAMER_CHECKSUM_EN
    push_w(16'hD110);
`endif
    wait_words(1);
    check_word(0, 16'hBEEF, 1'b1, 1'b1, 4'h7);
    check("s5_opcode", pkt_opcode, 4'h7);
    check("s5_chk_ok", chk_ok_n, CK);
    check("s5_count", pkt_count, 1);

    // Reset during the second payload word of a length-4 packet
    do_reset(2);
    push_w(16'h3004);
    for (int i = 1; i <= 4; i++) push_w(16'hC000 + 16'(i));
    t = 0;
    while (cap_data.size() < 1 && t < 100) begin
      tick();
      t++;
    end
    check("s6_first_word", cap_data.size(), 1);
    do_reset(2);
    @(negedge sys_clk);
    check("s6_count_after_rst", pkt_count, 0);
    tick();
    send_first_pkt();
    check_first_pkt("s6");
    check("s6_no_hdr_err", hdr_err_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
